change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Coin-output side of the ticket machine: pays a change amount as timed coin pulses (10/5/1 yuan).
//  Mirrors the coin-input path: ticket logic requests payout with start/amount, block drives hopper pulses.
//  Tracks per-denomination hopper inventory and substitutes smaller coins when a hopper is empty.
//  Flags a shortfall when exact change cannot be paid.
// PARAMETERS
//  AMT_W     8   width of amount/remaining (yuan)
//  INV_W     6   width of each hopper inventory counter
//  PULSE_CYC 4   coin pulse high time, clk cycles (>=1)
//  GAP_CYC   4   low time after each pulse, clk cycles (>=1)
//  INIT_10   10  hopper count loaded on reset/refill, 10-yuan coins
//  INIT_5    10  same, 5-yuan
//  INIT_1    20  same, 1-yuan
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      1-cycle request; accepted only in IDLE
//  amount     in   AMT_W  change to pay, sampled when start accepted
//  refill     in   1      1-cycle pulse: reload all hoppers to INIT_*; honoured only in IDLE
//  busy       out  1      high in every state except IDLE
//  coin10_out out  1      10-yuan hopper pulse
//  coin5_out  out  1      5-yuan hopper pulse
//  coin1_out  out  1      1-yuan hopper pulse
//  done       out  1      1-cycle pulse at end of every accepted request
//  short      out  1      latched: last request could not be fully paid
//  remaining  out  AMT_W  unpaid amount; holds final value after done
//  inv10/inv5/inv1 out INV_W  current hopper counts
// BEHAVIOUR
//  Reset: state IDLE; busy/coin*_out/done/short=0; remaining=0; inv*=INIT_*.
//  FSM: IDLE -> SELECT -> PULSE -> GAP -> SELECT ... -> DONE | FAULT -> IDLE.
//  IDLE: start loads remaining<=amount, clears short, goes SELECT next cycle. start while busy ignored.
//  SELECT (1 cycle): pick largest d in {10,5,1} with d<=remaining and inv_d>0.
//   remaining==0 -> DONE; no eligible d with remaining>0 -> FAULT; else PULSE with d.
//  PULSE: exactly one coin*_out high for PULSE_CYC cycles; on last cycle remaining-=d, inv_d-=1.
//  GAP: all coin outputs low for GAP_CYC cycles, then SELECT.
//  DONE: done=1 one cycle, -> IDLE. FAULT: done=1, short<=1, remaining holds unpaid value, -> IDLE.
//  Latency: done high 2+N*(1+PULSE_CYC+GAP_CYC) cycles after start edge, N = coins paid.
//  Inventory never underflows (selection requires inv_d>0); no subtraction wrap possible.
//  start & refill same IDLE cycle: inventory reloads that cycle; first SELECT sees reloaded counts.
//  short cleared only by next accepted start or refill (or reset).
//  Coin outputs registered, glitch-free, never more than one high at once.
//  Reset mid-pulse: outputs drop immediately (async); partial coin not counted.
// CONFIGURATION
//  CHANGE_TALLY_EN defined: extra out port total_paid [15:0], adds d on each completed pulse,
//   cleared by reset only, saturates at 16'hFFFF.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package change_pkg: FSM state encoding, denomination constants (10/5/1), denomination select code.
//  Sub-module pulse_timer: loadable down-counter giving PULSE/GAP expiry; shared by both states.
//  Denomination selection is combinational inside change_dispenser.
// TESTING
//  Defaults, amount=16 -> one pulse each coin10, coin5, coin1 in that order; done at cycle 29; remaining=0.
//  amount=0 -> no pulses; done at cycle 2; short=0.
//  INIT_10=0, amount=10 -> two coin5 pulses; inv5 10->8; inv10 stays 0.
//  inv5=1, inv1=2 (via params), amount=8, inv10 any -> 5,1,1 paid; done with short=1, remaining=1.
//  start pulsed mid-payout and refill while busy -> both ignored; inventory/remaining unaffected.
//  rst_n low during PULSE of amount=10 -> coin10_out low at once; inv10=INIT_10; CHANGE_TALLY_EN: total_paid=0, then 16 after amount=16.

Source files
------------

// File: rtl/change_pkg.sv
// Shared types for the change dispenser: FSM states, denomination select codes and coin values.
package change_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PULSE,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_10,
    SEL_5,
    SEL_1
  } denom_e;

  localparam int unsigned DENOM_10 = 10;
  localparam int unsigned DENOM_5  = 5;
  localparam int unsigned DENOM_1  = 1;
  localparam int unsigned TALLY_W  = 16;

  function automatic int unsigned denom_value(denom_e d);
    case (d)
      SEL_10:  return DENOM_10;
      SEL_5:   return DENOM_5;
      SEL_1:   return DENOM_1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module pulse_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount as timed 10/5/1-yuan hopper pulses, substituting smaller coins when a hopper is empty.
// Optional: define CHANGE_TALLY_EN to add the saturating total_paid counter port.
module change_dispenser
  import change_pkg::*;
#(
  parameter int AMT_W     = 8,
  parameter int INV_W     = 6,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int INIT_10   = 10,
  parameter int INIT_5    = 10,
  parameter int INIT_1    = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  output logic             busy,
  output logic             coin10_out,
  output logic             coin5_out,
  output logic             coin1_out,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [INV_W-1:0] inv10,
  output logic [INV_W-1:0] inv5,
  output logic [INV_W-1:0] inv1
`ifdef CHANGE_TALLY_EN
  ,
  output logic [TALLY_W-1:0] total_paid
`endif
);

  localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYC - 1);
  localparam logic [AMT_W-1:0] D10 = AMT_W'(DENOM_10);
  localparam logic [AMT_W-1:0] D5  = AMT_W'(DENOM_5);
  localparam logic [AMT_W-1:0] D1  = AMT_W'(DENOM_1);
  localparam logic [INV_W-1:0] INV10_INIT = INV_W'(INIT_10);
  localparam logic [INV_W-1:0] INV5_INIT  = INV_W'(INIT_5);
  localparam logic [INV_W-1:0] INV1_INIT  = INV_W'(INIT_1);

  state_e           state_q, state_d;
  denom_e           sel_q, sel_d, sel_pick;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [INV_W-1:0] inv10_q, inv10_d, inv5_q, inv5_d, inv1_q, inv1_d;
  logic             short_q, short_d;
  logic             busy_q, done_q, coin10_q, coin5_q, coin1_q;
  logic             tmr_load, tmr_expired;
  logic [TMR_W-1:0] tmr_val;

  pulse_timer #(.CNT_W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // Largest coin that fits the unpaid amount and is still in stock.
  always_comb begin
    sel_pick = SEL_NONE;
    if (rem_q >= D10 && inv10_q != '0) begin
      sel_pick = SEL_10;
    end else if (rem_q >= D5 && inv5_q != '0) begin
      sel_pick = SEL_5;
    end else if (rem_q >= D1 && inv1_q != '0) begin
      sel_pick = SEL_1;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rem_d    = rem_q;
    inv10_d  = inv10_q;
    inv5_d   = inv5_q;
    inv1_d   = inv1_q;
    short_d  = short_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (refill) begin
          inv10_d = INV10_INIT;
          inv5_d  = INV5_INIT;
          inv1_d  = INV1_INIT;
          short_d = 1'b0;
        end
        if (start) begin
          rem_d   = amount;
          short_d = 1'b0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else if (sel_pick == SEL_NONE) begin
          state_d = ST_FAULT;
        end else begin
          sel_d    = sel_pick;
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
        end
      end
      ST_PULSE: begin
        if (tmr_expired) begin
          rem_d = rem_q - AMT_W'(denom_value(sel_q));
          case (sel_q)
            SEL_10:  inv10_d = inv10_q - 1'b1;
            SEL_5:   inv5_d  = inv5_q - 1'b1;
            SEL_1:   inv1_d  = inv1_q - 1'b1;
            default: ;
          endcase
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (tmr_expired) state_d = ST_SELECT;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAULT: begin
        short_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state so the coin lines are glitch-free and
  // track the PULSE state exactly; done trails DONE/FAULT by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_NONE;
      rem_q    <= '0;
      inv10_q  <= INV10_INIT;
      inv5_q   <= INV5_INIT;
      inv1_q   <= INV1_INIT;
      short_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      coin10_q <= 1'b0;
      coin5_q  <= 1'b0;
      coin1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rem_q    <= rem_d;
      inv10_q  <= inv10_d;
      inv5_q   <= inv5_d;
      inv1_q   <= inv1_d;
      short_q  <= short_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_q == ST_DONE) || (state_q == ST_FAULT);
      coin10_q <= (state_d == ST_PULSE) && (sel_d == SEL_10);
      coin5_q  <= (state_d == ST_PULSE) && (sel_d == SEL_5);
      coin1_q  <= (state_d == ST_PULSE) && (sel_d == SEL_1);
    end
  end

`ifdef CHANGE_TALLY_EN
  logic [TALLY_W-1:0] total_q, total_d;
  logic [TALLY_W:0]   total_sum;

  always_comb begin
    total_sum = {1'b0, total_q} + (TALLY_W + 1)'(denom_value(sel_q));
    total_d   = total_q;
    if (state_q == ST_PULSE && tmr_expired) begin
      total_d = total_sum[TALLY_W] ? '1 : total_sum[TALLY_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total_paid = total_q;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign short      = short_q;
  assign remaining  = rem_q;
  assign inv10      = inv10_q;
  assign inv5       = inv5_q;
  assign inv1       = inv1_q;
  assign coin10_out = coin10_q;
  assign coin5_out  = coin5_q;
  assign coin1_out  = coin1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: three instances with different hopper loads, checked against a greedy payout model.
module tb_change_dispenser;

  localparam int NI = 3;
  localparam int I10 [NI] = '{10, 0, 10};
  localparam int I5  [NI] = '{10, 10, 1};
  localparam int I1  [NI] = '{20, 20, 2};
  localparam int COIN_CYC = 9;
  localparam int PULSE_LEN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a  [NI];
  logic [7:0] amount_a [NI];
  logic       refill_a [NI];
  logic       busy_a [NI], c10_a [NI], c5_a [NI], c1_a [NI], done_a [NI], short_a [NI];
  logic [7:0] rem_a [NI];
  logic [5:0] inv10_a [NI], inv5_a [NI], inv1_a [NI];
`ifdef CHANGE_TALLY_EN
  logic [15:0] tot_a [NI];
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: m_inv[k][0..2] = hopper counts for 10, 5, 1 yuan.
  int m_inv [NI][3];
  int m_tally [NI];
  int denoms [3] = '{10, 5, 1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    change_dispenser #(
      .INIT_10 (I10[g]),
      .INIT_5  (I5[g]),
      .INIT_1  (I1[g])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_a[g]),
      .amount     (amount_a[g]),
      .refill     (refill_a[g]),
      .busy       (busy_a[g]),
      .coin10_out (c10_a[g]),
      .coin5_out  (c5_a[g]),
      .coin1_out  (c1_a[g]),
      .done       (done_a[g]),
      .short      (short_a[g]),
      .remaining  (rem_a[g]),
      .inv10      (inv10_a[g]),
      .inv5       (inv5_a[g]),
      .inv1       (inv1_a[g])
`ifdef CHANGE_TALLY_EN
      ,
      .total_paid (tot_a[g])
`endif
    );
  end

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_inv[k][0] = I10[k];
      m_inv[k][1] = I5[k];
      m_inv[k][2] = I1[k];
      m_tally[k]  = 0;
    end
  endtask

  task automatic check_inv(input int k, input string tag);
    tests_run++;
    if (inv10_a[k] !== 6'(m_inv[k][0]) || inv5_a[k] !== 6'(m_inv[k][1]) || inv1_a[k] !== 6'(m_inv[k][2])) begin
      tests_failed++;
      $display("FAIL %s inv[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", tag, k,
               inv10_a[k], inv5_a[k], inv1_a[k], m_inv[k][0], m_inv[k][1], m_inv[k][2]);
    end
  endtask

  // One request on instance k; optional refill in the same cycle, optional ignored start/refill mid-payout.
  task automatic run_req(input int k, input int amt, input bit with_refill, input bit inject, input string tag);
    int exp_coins[$];
    int got_coins[$];
    int r, budget, done_cyc, run_len, j;
    logic [2:0] coins, prev;
    bit seq_ok, do_inject;
    int new_inv [3];

    if (with_refill) begin
      m_inv[k][0] = I10[k];
      m_inv[k][1] = I5[k];
      m_inv[k][2] = I1[k];
    end
    r = amt;
    while (r > 0) begin
      j = 0;
      while (j < 3 && !(denoms[j] <= r && m_inv[k][j] > 0)) j++;
      if (j == 3) break;
      exp_coins.push_back(denoms[j]);
      r -= denoms[j];
      m_inv[k][j]--;
      m_tally[k] = (m_tally[k] + denoms[j] > 16'hFFFF) ? 16'hFFFF : m_tally[k] + denoms[j];
    end
    do_inject = inject && (exp_coins.size() >= 2);

    @(negedge clk);
    start_a[k]  = 1'b1;
    amount_a[k] = 8'(amt);
    refill_a[k] = with_refill;
    @(posedge clk);
    #1;
    start_a[k]  = 1'b0;
    refill_a[k] = 1'b0;

    budget   = 2 + (exp_coins.size() + 1) * COIN_CYC + 10;
    done_cyc = -1;
    run_len  = 0;
    prev     = 3'b000;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk);
      #1;
      if (do_inject) begin
        if (cyc == 5)  begin start_a[k] = 1'b1; amount_a[k] = 8'd200; end
        if (cyc == 6)  start_a[k] = 1'b0;
        if (cyc == 13) refill_a[k] = 1'b1;
        if (cyc == 14) refill_a[k] = 1'b0;
      end
      coins = {c10_a[k], c5_a[k], c1_a[k]};
      if ($countones(coins) > 1) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s one-hot coins: got %b at cycle %0d", tag, coins, cyc);
      end
      if (cyc == 1) begin
        tests_run++;
        if (busy_a[k] !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s busy after start: got %b expected 1", tag, busy_a[k]);
        end
      end
      if (coins != 3'b000 && prev == 3'b000)
        got_coins.push_back(coins[2] ? 10 : coins[1] ? 5 : 1);
      if (coins != 3'b000) begin
        run_len++;
      end else if (prev != 3'b000) begin
        tests_run++;
        if (run_len != PULSE_LEN) begin
          tests_failed++;
          $display("FAIL %s pulse width: got %0d expected %0d", tag, run_len, PULSE_LEN);
        end
        run_len = 0;
      end
      prev = coins;
      if (done_a[k] === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end

    tests_run++;
    if (done_cyc != 2 + int'(exp_coins.size()) * COIN_CYC) begin
      tests_failed++;
      $display("FAIL %s done latency: got %0d expected %0d", tag, done_cyc,
               2 + int'(exp_coins.size()) * COIN_CYC);
    end
    seq_ok = (got_coins.size() == exp_coins.size());
    for (int i = 0; i < got_coins.size() && seq_ok; i++) seq_ok = (got_coins[i] == exp_coins[i]);
    tests_run++;
    if (!seq_ok) begin
      tests_failed++;
      $display("FAIL %s coin sequence: got %p expected %p", tag, got_coins, exp_coins);
    end
    tests_run++;
    if (rem_a[k] !== 8'(r) || short_a[k] !== (r != 0) || busy_a[k] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s result: got rem=%0d short=%b busy=%b expected rem=%0d short=%b busy=0",
               tag, rem_a[k], short_a[k], busy_a[k], r, (r != 0));
    end
    check_inv(k, tag);
`ifdef CHANGE_TALLY_EN
    tests_run++;
    if (tot_a[k] !== 16'(m_tally[k])) begin
      tests_failed++;
      $display("FAIL %s total_paid: got %0d expected %0d", tag, tot_a[k], m_tally[k]);
    end
`endif
    @(posedge clk);
    #1;
    tests_run++;
    if (done_a[k] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done width: still high one cycle later", tag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    for (int k = 0; k < NI; k++) begin
      tests_run++;
      if (busy_a[k] !== 1'b0 || done_a[k] !== 1'b0 || short_a[k] !== 1'b0 || rem_a[k] !== 8'd0 ||
          {c10_a[k], c5_a[k], c1_a[k]} !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset outputs[%0d]: got busy=%b done=%b short=%b rem=%0d coins=%b expected all 0",
                 k, busy_a[k], done_a[k], short_a[k], rem_a[k], {c10_a[k], c5_a[k], c1_a[k]});
      end
      check_inv(k, "reset");
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_req(0, 16, 1'b0, 1'b0, "amount16");
    run_req(0, 0, 1'b0, 1'b0, "amount0");
  endtask

  task automatic test_substitution();
    run_req(1, 10, 1'b0, 1'b0, "no_tens");
  endtask

  task automatic test_shortfall();
    run_req(2, 8, 1'b0, 1'b0, "shortfall");
  endtask

  task automatic test_refill();
    @(negedge clk);
    refill_a[2] = 1'b1;
    @(negedge clk);
    refill_a[2] = 1'b0;
    m_inv[2][0] = I10[2];
    m_inv[2][1] = I5[2];
    m_inv[2][2] = I1[2];
    tests_run++;
    if (short_a[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL refill short clear: got %b expected 0", short_a[2]);
    end
    check_inv(2, "refill");
    run_req(0, 27, 1'b1, 1'b0, "start_refill");
  endtask

  task automatic test_ignored_while_busy();
    run_req(0, 30, 1'b0, 1'b1, "ignored_inputs");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_req($urandom_range(0, NI - 1), $urandom_range(0, 70), $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1, "random");
    end
  endtask

  task automatic test_reset_mid_pulse();
    @(negedge clk);
    start_a[0]  = 1'b1;
    amount_a[0] = 8'd10;
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (c10_a[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pulse coin10 before reset: got %b expected 1", c10_a[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (c10_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || rem_a[0] !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_pulse reset: got coin10=%b busy=%b rem=%0d expected 0/0/0",
               c10_a[0], busy_a[0], rem_a[0]);
    end
    check_inv(0, "mid_pulse");
`ifdef CHANGE_TALLY_EN
    tests_run++;
    if (tot_a[0] !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_pulse total_paid: got %0d expected 0", tot_a[0]);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_req(0, 16, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      start_a[k]  = 1'b0;
      amount_a[k] = 8'd0;
      refill_a[k] = 1'b0;
    end
    test_reset();
    test_basic();
    test_substitution();
    test_shortfall();
    test_refill();
    test_ignored_while_busy();
    test_random();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
